dsp_multacc_seq: RTL and testbench

- Initiator-side sequencer that drives a DSP38 MULTIPLY_ACCUMULATE instance configured with output register on and input register off.
- Accepts a valid/ready stream of operand pairs and computes one dot product per vector of cfg_len pairs.
- Manages dsp_load_acc and operand zeroing, waits out the DSP latency, and returns each 38-bit result on a valid/ready output port.
- Sits between a datapath producer and the DSP primitive.

---
 rtl/dsp_multacc_seq.sv | 214 +++++++++++++++++++++
 tb/tb_dsp_multacc_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_multacc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_multacc_seq
//  Purpose  : Initiator-side sequencer for a DSP38 MULTIPLY_ACCUMULATE slice
//             (output register on, input register off). Takes a valid/ready
//             stream of (A,B) operand pairs, runs one dot product per vector
//             of cfg_len pairs, waits out the DSP latency and returns the
//             raw 38-bit Z on a valid/ready result port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, lreset            : clock, synchronous active-high reset (also the
//                             DSP RESET)
//    cfg_*                  : vector configuration, sampled on a vector's
//                             first beat only
//    s_valid/s_ready/s_a/s_b: operand beat stream
//    m_valid/m_ready/m_z    : dot-product result stream
//    dsp_*                  : registered drive to / raw Z from the DSP slice
//    busy                   : high whenever the sequencer is not idle
// ============================================================================
module dsp_multacc_seq #(
    parameter int LEN_W = 8,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             lreset,
    // vector configuration
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_unsigned_a,
    input  logic             cfg_unsigned_b,
    input  logic             cfg_subtract,
    input  logic [5:0]       cfg_shift_right,
    input  logic             cfg_round,
    input  logic             cfg_saturate,
    // operand stream
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [19:0]      s_a,
    input  logic [17:0]      s_b,
    // result stream
    output logic             m_valid,
    input  logic             m_ready,
    output logic [37:0]      m_z,
    // DSP slice interface
    output logic [19:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [2:0]       dsp_feedback,
    output logic             dsp_load_acc,
    output logic             dsp_unsigned_a,
    output logic             dsp_unsigned_b,
    output logic             dsp_subtract,
    output logic [5:0]       dsp_shift_right,
    output logic             dsp_round,
    output logic             dsp_saturate,
    input  logic [37:0]      dsp_z,
    // status
    output logic             busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACC   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_OUT   = 2'd3;

    // Drain counter: loaded with LAT on the last-beat edge and counted down
    // to zero, so Z is captured LAT+1 edges after the last acceptance.
    localparam int                   c_DRAIN_W    = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(LAT);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam logic [LEN_W-1:0]     c_LEN_ONE    = LEN_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [LEN_W-1:0]     r_cnt;
    logic [c_DRAIN_W-1:0] r_drain;
    logic                 r_m_valid;
    logic [37:0]          r_m_z;
    logic [19:0]          r_dsp_a;
    logic [17:0]          r_dsp_b;
    logic                 r_load_acc;
    logic                 r_unsigned_a;
    logic                 r_unsigned_b;
    logic                 r_subtract;
    logic [5:0]           r_shift_right;
    logic                 r_round;
    logic                 r_saturate;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_s_ready;
    logic             w_accept;
    logic [LEN_W-1:0] w_len_m1;

    // Ready is decoded from the state register; gating with lreset keeps
    // the stream stalled for the whole time reset is held, including the
    // very first reset cycle before any edge has been seen.
    assign w_s_ready = !lreset && ((r_state == c_ST_IDLE) || (r_state == c_ST_ACC));
    assign w_accept  = s_valid && w_s_ready;

    // Remaining beats after the first one; a length of zero behaves as one.
    assign w_len_m1  = (cfg_len == '0) ? '0 : (cfg_len - c_LEN_ONE);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (lreset) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_drain       <= '0;
            r_m_valid     <= 1'b0;
            r_m_z         <= '0;
            r_dsp_a       <= '0;
            r_dsp_b       <= '0;
            r_load_acc    <= 1'b0;
            r_unsigned_a  <= 1'b0;
            r_unsigned_b  <= 1'b0;
            r_subtract    <= 1'b0;
            r_shift_right <= '0;
            r_round       <= 1'b0;
            r_saturate    <= 1'b0;
        end else begin
            // Operands are zero on every cycle without an accepted beat so
            // the free-running accumulator adds nothing and just holds.
            r_dsp_a    <= '0;
            r_dsp_b    <= '0;
            r_load_acc <= 1'b0;
            if (w_accept) begin
                r_dsp_a <= s_a;
                r_dsp_b <= s_b;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        // First beat: restart the accumulator and freeze the
                        // vector configuration until the next first beat.
                        r_load_acc    <= 1'b1;
                        r_unsigned_a  <= cfg_unsigned_a;
                        r_unsigned_b  <= cfg_unsigned_b;
                        r_subtract    <= cfg_subtract;
                        r_shift_right <= cfg_shift_right;
                        r_round       <= cfg_round;
                        r_saturate    <= cfg_saturate;
                        r_cnt         <= w_len_m1;
                        if (w_len_m1 == '0) begin
                            r_state <= c_ST_DRAIN;
                            r_drain <= c_DRAIN_INIT;
                        end else begin
                            r_state <= c_ST_ACC;
                        end
                    end
                end

                c_ST_ACC: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - c_LEN_ONE;
                        if (r_cnt == c_LEN_ONE) begin
                            r_state <= c_ST_DRAIN;
                            r_drain <= c_DRAIN_INIT;
                        end
                    end
                end

                c_ST_DRAIN: begin
                    if (r_drain == '0) begin
                        r_m_z     <= dsp_z;
                        r_m_valid <= 1'b1;
                        r_state   <= c_ST_OUT;
                    end else begin
                        r_drain <= r_drain - c_DRAIN_ONE;
                    end
                end

                c_ST_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready         = w_s_ready;
    assign m_valid         = r_m_valid;
    assign m_z             = r_m_z;
    assign dsp_a           = r_dsp_a;
    assign dsp_b           = r_dsp_b;
    assign dsp_feedback    = 3'b000;
    assign dsp_load_acc    = r_load_acc;
    assign dsp_unsigned_a  = r_unsigned_a;
    assign dsp_unsigned_b  = r_unsigned_b;
    assign dsp_subtract    = r_subtract;
    assign dsp_shift_right = r_shift_right;
    assign dsp_round       = r_round;
    assign dsp_saturate    = r_saturate;
    assign busy            = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dsp_multacc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_multacc_seq
//  Purpose  : Self-checking bench for dsp_multacc_seq with a behavioural
//             DSP38 accumulator stub and a dot-product reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_multacc_seq;

    localparam int LEN_W = 8;
    localparam int LAT   = 1;

    logic             clk = 1'b0;
    logic             lreset;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_unsigned_a;
    logic             cfg_unsigned_b;
    logic             cfg_subtract;
    logic [5:0]       cfg_shift_right;
    logic             cfg_round;
    logic             cfg_saturate;
    logic             s_valid;
    logic             s_ready;
    logic [19:0]      s_a;
    logic [17:0]      s_b;
    logic             m_valid;
    logic             m_ready;
    logic [37:0]      m_z;
    logic [19:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [2:0]       dsp_feedback;
    logic             dsp_load_acc;
    logic             dsp_unsigned_a;
    logic             dsp_unsigned_b;
    logic             dsp_subtract;
    logic [5:0]       dsp_shift_right;
    logic             dsp_round;
    logic             dsp_saturate;
    logic [37:0]      dsp_z;
    logic             busy;

    always #5 clk = ~clk;

    dsp_multacc_seq #(.LEN_W(LEN_W), .LAT(LAT)) dut (
        .clk             (clk),
        .lreset          (lreset),
        .cfg_len         (cfg_len),
        .cfg_unsigned_a  (cfg_unsigned_a),
        .cfg_unsigned_b  (cfg_unsigned_b),
        .cfg_subtract    (cfg_subtract),
        .cfg_shift_right (cfg_shift_right),
        .cfg_round       (cfg_round),
        .cfg_saturate    (cfg_saturate),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_a             (s_a),
        .s_b             (s_b),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_z             (m_z),
        .dsp_a           (dsp_a),
        .dsp_b           (dsp_b),
        .dsp_feedback    (dsp_feedback),
        .dsp_load_acc    (dsp_load_acc),
        .dsp_unsigned_a  (dsp_unsigned_a),
        .dsp_unsigned_b  (dsp_unsigned_b),
        .dsp_subtract    (dsp_subtract),
        .dsp_shift_right (dsp_shift_right),
        .dsp_round       (dsp_round),
        .dsp_saturate    (dsp_saturate),
        .dsp_z           (dsp_z),
        .busy            (busy)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // DSP arithmetic rules (operand extension and Z post-processing)
    // ------------------------------------------------------------------
    function automatic longint ext_a(input logic [19:0] v, input logic u);
        return u ? longint'({44'd0, v}) : longint'({{44{v[19]}}, v});
    endfunction

    function automatic longint ext_b(input logic [17:0] v, input logic u);
        return u ? longint'({46'd0, v}) : longint'({{46{v[17]}}, v});
    endfunction

    function automatic logic [37:0] dsp_out(input longint acc, input logic [5:0] sh,
                                            input logic rnd, input logic sat);
        longint v;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< 37) - 1;
        lo = -(longint'(1) <<< 37);
        v  = acc;
        if (rnd && sh != 6'd0) v = v + (longint'(1) <<< (sh - 6'd1));
        v = v >>> sh;
        if (sat) begin
            if (v > hi)      v = hi;
            else if (v < lo) v = lo;
        end
        return v[37:0];
    endfunction

    // DSP38 stub: accumulator updates every edge, Z visible combinationally
    // from the registered accumulator (LAT = 1).
    longint r_acc;
    always @(posedge clk) begin
        if (lreset)
            r_acc <= 0;
        else if (dsp_load_acc)
            r_acc <= ext_a(dsp_a, dsp_unsigned_a) * ext_b(dsp_b, dsp_unsigned_b);
        else if (dsp_subtract)
            r_acc <= r_acc - ext_a(dsp_a, dsp_unsigned_a) * ext_b(dsp_b, dsp_unsigned_b);
        else
            r_acc <= r_acc + ext_a(dsp_a, dsp_unsigned_a) * ext_b(dsp_b, dsp_unsigned_b);
    end
    assign dsp_z = dsp_out(r_acc, dsp_shift_right, dsp_round, dsp_saturate);

    // ------------------------------------------------------------------
    // Reference model: dot product of the queued vector
    // ------------------------------------------------------------------
    logic [19:0] qa[$];
    logic [17:0] qb[$];

    function automatic logic [37:0] ref_dot(input bit ua, input bit ub, input bit sub,
                                            input logic [5:0] sh, input bit rnd, input bit sat);
        longint s;
        s = 0;
        foreach (qa[i]) begin
            longint p;
            p = ext_a(qa[i], ua) * ext_b(qb[i], ub);
            if (i == 0)   s = p;
            else if (sub) s = s - p;
            else          s = s + p;
        end
        return dsp_out(s, sh, rnd, sat);
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag, input logic exp_ready);
        check({tag, "_s_ready"}, 64'(s_ready), 64'(exp_ready));
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_z"},     64'(m_z),     64'd0);
        check({tag, "_busy"},    64'(busy),    64'd0);
        check({tag, "_dsp_ab"},  64'({dsp_a, dsp_b}), 64'd0);
        check({tag, "_dsp_cfg"}, 64'({dsp_feedback, dsp_load_acc, dsp_unsigned_a, dsp_unsigned_b,
                                      dsp_subtract, dsp_shift_right, dsp_round, dsp_saturate}), 64'd0);
    endtask

    task automatic scramble_cfg();
        cfg_len         = LEN_W'($urandom);
        cfg_unsigned_a  = 1'($urandom_range(0, 1));
        cfg_unsigned_b  = 1'($urandom_range(0, 1));
        cfg_subtract    = 1'($urandom_range(0, 1));
        cfg_shift_right = 6'($urandom);
        cfg_round       = 1'($urandom_range(0, 1));
        cfg_saturate    = 1'($urandom_range(0, 1));
    endtask

    // Present one beat, wait (bounded) for acceptance, then check the
    // registered DSP drive in the cycle after the acceptance edge.
    task automatic send_beat(input string tag, input logic [19:0] a, input logic [17:0] b,
                             input bit first);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_beat_timeout"}, 64'(n < 20), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_a     = 20'($urandom);
        s_b     = 18'($urandom);
        check({tag, "_dsp_a"},    64'(dsp_a),        64'(a));
        check({tag, "_dsp_b"},    64'(dsp_b),        64'(b));
        check({tag, "_load_acc"}, 64'(dsp_load_acc), 64'(first));
    endtask

    task automatic gap_cycles(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            check({tag, "_gap_ops"},   64'({dsp_a, dsp_b}), 64'd0);
            check({tag, "_gap_load"},  64'(dsp_load_acc),   64'd0);
            check({tag, "_gap_ready"}, 64'(s_ready),        64'd1);
        end
    endtask

    // Run one vector from qa/qb, check latency, result, hold and handshake.
    task automatic run_vec(input string tag, input int len, input bit ua, input bit ub,
                           input bit sub, input logic [5:0] sh, input bit rnd, input bit sat,
                           input int gap, input int hold, output logic [37:0] got);
        logic [37:0] exp_z;
        exp_z           = ref_dot(ua, ub, sub, sh, rnd, sat);
        cfg_len         = LEN_W'(len);
        cfg_unsigned_a  = ua;
        cfg_unsigned_b  = ub;
        cfg_subtract    = sub;
        cfg_shift_right = sh;
        cfg_round       = rnd;
        cfg_saturate    = sat;
        for (int i = 0; i < qa.size(); i++) begin
            send_beat(tag, qa[i], qb[i], (i == 0));
            if (i == 0) scramble_cfg();
            if (i < qa.size() - 1) gap_cycles(tag, gap);
        end
        for (int k = 0; k <= LAT; k++) begin
            check({tag, "_early_valid"}, 64'(m_valid), 64'd0);
            check({tag, "_drain_ready"}, 64'(s_ready), 64'd0);
            if (k > 0) begin
                check({tag, "_drain_ops"},  64'({dsp_a, dsp_b}), 64'd0);
                check({tag, "_drain_load"}, 64'(dsp_load_acc),   64'd0);
            end
            @(negedge clk);
        end
        check({tag, "_m_valid"},   64'(m_valid), 64'd1);
        check({tag, "_m_z"},       64'(m_z),     64'(exp_z));
        check({tag, "_out_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_out_busy"},  64'(busy),    64'd1);
        check({tag, "_cfg_out"},
              64'({dsp_unsigned_a, dsp_unsigned_b, dsp_subtract, dsp_shift_right, dsp_round, dsp_saturate}),
              64'({ua, ub, sub, sh, rnd, sat}));
        got = m_z;
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(m_valid), 64'd1);
            check({tag, "_hold_z"},     64'(m_z),     64'(exp_z));
            check({tag, "_hold_ready"}, 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_done_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(s_ready), 64'd1);
        check({tag, "_done_busy"},  64'(busy),    64'd0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin
        logic [37:0] got;
        int          len;
        int          nb;

        lreset  = 1'b1;
        s_valid = 1'b1;
        s_a     = 20'($urandom);
        s_b     = 18'($urandom);
        m_ready = 1'b0;
        scramble_cfg();

        // Reset state, then the cycle after release
        repeat (3) @(negedge clk);
        check_reset("rst_hold", 1'b0);
        lreset  = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check_reset("rst_after", 1'b1);

        // 1. back-to-back unsigned vector
        qa = {20'd1, 20'd3, 20'd5, 20'd7};
        qb = {18'd2, 18'd4, 18'd6, 18'd8};
        run_vec("t1", 4, 1, 1, 0, 6'd0, 0, 0, 0, 0, got);
        check("t1_const", 64'(got), 64'd100);

        // 2. same vector with three idle cycles between beats
        run_vec("t2", 4, 1, 1, 0, 6'd0, 0, 0, 3, 0, got);
        check("t2_const", 64'(got), 64'd100);

        // 3. signed operands
        qa = {20'hFFFFD, 20'hFFFFE};
        qb = {18'd5, 18'h3FFF9};
        run_vec("t3", 2, 0, 0, 0, 6'd0, 0, 0, 0, 0, got);
        check("t3_const", 64'(got), 64'h3F_FFFF_FFFF);

        // 4. result back-pressure, then length 0 vector with no carry
        qa = {20'd1, 20'd3, 20'd5, 20'd7};
        qb = {18'd2, 18'd4, 18'd6, 18'd8};
        run_vec("t4a", 4, 1, 1, 0, 6'd0, 0, 0, 0, 5, got);
        qa = {20'd9};
        qb = {18'd9};
        run_vec("t4b", 0, 1, 1, 0, 6'd0, 0, 0, 0, 0, got);
        check("t4b_const", 64'(got), 64'd81);

        // 5. subtract after the first product
        qa = {20'd10, 20'd2, 20'd1};
        qb = {18'd10, 18'd3, 18'd4};
        run_vec("t5", 3, 0, 0, 1, 6'd0, 0, 0, 0, 0, got);
        check("t5_const", 64'(got), 64'd90);

        // 6. reset in the middle of a vector
        cfg_len         = 8'd4;
        cfg_unsigned_a  = 1'b1;
        cfg_unsigned_b  = 1'b1;
        cfg_subtract    = 1'b0;
        cfg_shift_right = 6'd3;
        cfg_round       = 1'b1;
        cfg_saturate    = 1'b1;
        send_beat("t6_pre", 20'd11, 18'd12, 1'b1);
        send_beat("t6_pre", 20'd13, 18'd14, 1'b0);
        lreset = 1'b1;
        @(negedge clk);
        check_reset("t6_rst", 1'b0);
        lreset = 1'b0;
        @(negedge clk);
        check_reset("t6_after", 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_valid", 64'(m_valid), 64'd0);
            check("t6_idle",     64'(busy),    64'd0);
        end
        qa = {20'd2, 20'd4};
        qb = {18'd3, 18'd5};
        run_vec("t6", 2, 0, 0, 0, 6'd0, 0, 0, 0, 0, got);
        check("t6_const", 64'(got), 64'd26);

        // Random vectors: length, operands, signedness, shift/round/saturate,
        // gaps and back-pressure all drawn at random.
        for (int v = 0; v < 12; v++) begin
            len = $urandom_range(0, 6);
            nb  = (len == 0) ? 1 : len;
            qa.delete();
            qb.delete();
            for (int i = 0; i < nb; i++) begin
                qa.push_back(20'($urandom));
                qb.push_back(18'($urandom));
            end
            run_vec("rnd", len,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 6'($urandom_range(0, 8)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $urandom_range(0, 3), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
